uncache_axi_arbiter: RTL

Shares one single-beat AXI master port between the instruction-fetch and data-access uncached paths. It translates both requesters' virtual addresses with the fixed kseg0/kseg1 mapping and arbitrates between them. It then runs each granted request as one AXI read or write transaction and returns read data or write completion to the originating port. It sits between the IF/MEM-stage uncached request logic and the top-level AXI interconnect.

---
 rtl/uncache_axi_arbiter.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/uncache_axi_arbiter.sv
// Shares one single-beat AXI master port between the uncached instruction-fetch and
// data-access paths: kseg0/kseg1 translation, two-way arbitration, one transaction at a time.
module uncache_axi_arbiter #(
  parameter int unsigned DATA_PRIO = 0
) (
  input  logic        clk,
  input  logic        rst,
  // instruction port
  input  logic        i_req,
  input  logic [31:0] i_vaddr,
  output logic        i_ack,
  output logic        i_rsp_valid,
  output logic [31:0] i_rdata,
  // data port
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [1:0]  d_size,
  input  logic [31:0] d_vaddr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ack,
  output logic        d_rsp_valid,
  output logic [31:0] d_rdata,
  // AXI read address
  output logic [31:0] araddr,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  output logic [7:0]  arlen,
  output logic [1:0]  arburst,
  output logic [3:0]  arid,
  // AXI read data
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready,
  // AXI write address
  output logic [31:0] awaddr,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [7:0]  awlen,
  output logic [3:0]  awid,
  // AXI write data
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  output logic        wlast,
  // AXI write response
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {StIdle, StAr, StR, StAw, StB, StResp} state_e;

  state_e      state_q, state_d;
  logic        owner_q;       // 1 = data port owns the transaction in flight
  logic        last_grant_q;  // 1 = data port won most recently
  logic [31:0] paddr_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic [31:0] i_rdata_q, d_rdata_q;
  logic        arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic        i_rsp_q, d_rsp_q;

  logic arvalid_d, rready_d, awvalid_d, wvalid_d, bready_d, i_rsp_d, d_rsp_d;
  logic grant_data, take, aw_pend, w_pend;

  // kseg0/kseg1 (0x8000_0000-0xBFFF_FFFF) fold onto the low 512 MiB.
  function automatic logic [31:0] xlate(input logic [31:0] va);
    return (va[31:30] == 2'b10) ? {3'b000, va[28:0]} : va;
  endfunction

  always_comb begin
    grant_data = d_req && (!i_req || (DATA_PRIO != 0) || !last_grant_q);
    take       = (state_q == StIdle) && (i_req || d_req);
    i_ack      = take && !rst && !grant_data;
    d_ack      = take && !rst && grant_data;
    aw_pend    = awvalid_q && !awready;
    w_pend     = wvalid_q && !wready;

    state_d = state_q;
    unique case (state_q)
      StIdle: if (take) state_d = (grant_data && d_wr) ? StAw : StAr;
      StAr:   if (arready) state_d = StR;
      StR:    if (rvalid) state_d = StResp;
      StAw:   if (!aw_pend && !w_pend) state_d = StB;
      StB:    if (bvalid) state_d = StResp;
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Each write channel drops on its own handshake; both start together on entry.
    awvalid_d = ((state_q == StIdle) && (state_d == StAw)) || ((state_q == StAw) && aw_pend);
    wvalid_d  = ((state_q == StIdle) && (state_d == StAw)) || ((state_q == StAw) && w_pend);
    arvalid_d = (state_d == StAr);
    rready_d  = (state_d == StR);
    bready_d  = (state_d == StB);
    i_rsp_d   = (state_d == StResp) && !owner_q;
    d_rsp_d   = (state_d == StResp) && owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b0;
      paddr_q      <= '0;
      size_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      i_rsp_q      <= 1'b0;
      d_rsp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      i_rsp_q   <= i_rsp_d;
      d_rsp_q   <= d_rsp_d;
      if (take) begin
        owner_q      <= grant_data;
        last_grant_q <= grant_data;
        paddr_q      <= xlate(grant_data ? d_vaddr : i_vaddr);
        size_q       <= grant_data ? d_size : 2'd2;
        if (grant_data) begin
          wdata_q <= d_wdata;
          wstrb_q <= d_wstrb;
        end
      end
      if ((state_q == StR) && rvalid) begin
        if (owner_q) d_rdata_q <= rdata;
        else         i_rdata_q <= rdata;
      end
    end
  end

  assign i_rsp_valid = i_rsp_q;
  assign d_rsp_valid = d_rsp_q;
  assign i_rdata     = i_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign araddr      = paddr_q;
  assign awaddr      = paddr_q;
  assign arsize      = {1'b0, size_q};
  assign awsize      = {1'b0, size_q};
  assign arvalid     = arvalid_q;
  assign rready      = rready_q;
  assign awvalid     = awvalid_q;
  assign wvalid      = wvalid_q;
  assign bready      = bready_q;
  assign wdata       = wdata_q;
  assign wstrb       = wstrb_q;
  assign arlen       = 8'd0;
  assign arburst     = 2'b01;
  assign arid        = 4'd0;
  assign awlen       = 8'd0;
  assign awid        = 4'd0;
  assign wlast       = 1'b1;

endmodule
